// File: rtl/seven_seg_pkg.sv
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared constants for the 7-segment display blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seven_seg_pkg;

  localparam int SUB_SLOTS = 16;
  localparam int DEAD_SUB  = 0;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high gfedcba patterns, nibble 0 in the least significant 7 bits.
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/seven_seg_hex_dec.sv
// ============================================================================
// Module   : seven_seg_hex_dec
// Purpose  : Combinational hex nibble to active-high gfedcba decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_hex_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib*7 +: 7];

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_drv.sv
// ============================================================================
// Module   : seven_seg_scan_drv
// Purpose  : N-digit multiplexed common-anode 7-segment driver with PWM
//            brightness, dead slot and frame-synchronous input latching.
//            Optional macro LEADING_ZERO_SUPPRESS_EN adds port lz_en.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_drv
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SUB_CYC  = 390
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic [3:0]            bright,
`ifdef LEADING_ZERO_SUPPRESS_EN
  input  logic                  lz_en,
`endif
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int c_pre_w = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
  localparam int c_dig_w = $clog2(N_DIGITS);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SUB_CYC - 1);
  localparam logic [c_dig_w-1:0] c_dig_last = c_dig_w'(N_DIGITS - 1);
  localparam logic [3:0]         c_sub_last = 4'(SUB_SLOTS - 1);
  localparam logic [3:0]         c_sub_dead = 4'(DEAD_SUB);

  logic [c_pre_w-1:0]    r_pre;
  logic [3:0]            r_sub;
  logic [c_dig_w-1:0]    r_dig;
  logic [4*N_DIGITS-1:0] r_digits_s;
  logic [N_DIGITS-1:0]   r_dp_s;
  logic [N_DIGITS-1:0]   r_blank_s;
  logic [3:0]            r_bright_s;
  logic [N_DIGITS-1:0]   r_an_n;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic                  r_frame_tick;

  logic                  w_pre_wrap;
  logic                  w_sub_wrap;
  logic                  w_frame;
  logic [N_DIGITS-1:0]   w_blank_eff;
  logic [3:0]            w_nib;
  logic                  w_blank_cur;
  logic                  w_dp_cur;
  logic                  w_en;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_an_next;

  assign w_pre_wrap = (r_pre == c_pre_last);
  assign w_sub_wrap = w_pre_wrap && (r_sub == c_sub_last);
  assign w_frame    = w_sub_wrap && (r_dig == c_dig_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= '0;
      r_sub <= '0;
      r_dig <= '0;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) r_sub <= r_sub + 1'b1;
      // Explicit compare so non-power-of-two digit counts wrap cleanly.
      if (w_sub_wrap) r_dig <= (r_dig == c_dig_last) ? '0 : r_dig + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_digits_s <= '0;
      r_dp_s     <= '0;
      r_blank_s  <= '1;
      r_bright_s <= '0;
    end else if (w_frame) begin
      r_digits_s <= digits;
      r_dp_s     <= dp;
      r_blank_s  <= blank;
      r_bright_s <= bright;
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic [N_DIGITS-1:0] r_lz_mask;
  logic [N_DIGITS-1:0] w_lz_next;
  logic                w_zero_run;

  // Mask is built from the incoming inputs and latched with the shadows.
  always_comb begin
    w_lz_next  = '0;
    w_zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_zero_run   = w_zero_run && (digits[4*i +: 4] == 4'h0);
      w_lz_next[i] = lz_en && w_zero_run;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_lz_mask <= '0;
    else if (w_frame) r_lz_mask <= w_lz_next;
  end

  assign w_blank_eff = r_blank_s | r_lz_mask;
`else
  assign w_blank_eff = r_blank_s;
`endif

  always_comb begin
    w_nib       = 4'h0;
    w_blank_cur = 1'b1;
    w_dp_cur    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_dig == c_dig_w'(i)) begin
        w_nib       = r_digits_s[4*i +: 4];
        w_blank_cur = w_blank_eff[i];
        w_dp_cur    = r_dp_s[i];
      end
    end
  end

  assign w_en = !w_blank_cur && (r_sub != c_sub_dead) && (r_sub <= r_bright_s);

  seven_seg_hex_dec u_hex_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_dig == c_dig_w'(i)) w_an_next[i] = ~w_en;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_an_n       <= '1;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an_n       <= w_an_next;
      r_seg_n      <= w_en ? ~w_seg : SEG_OFF;
      r_dp_n       <= ~(w_dp_cur & w_en);
      r_frame_tick <= w_frame;
    end
  end

  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_drv.sv
// ============================================================================
// Module   : tb_seven_seg_scan_drv
// Purpose  : Directed self-checking bench, 3 digits, 2 clk per sub-slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_drv;

  localparam int N     = 3;
  localparam int SC    = 2;
  localparam int FRAME = 16 * SC * N;
  localparam int SLOT  = 16 * SC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] digits = 12'h000;
  logic [2:0]  dp = 3'b000;
  logic [2:0]  blank = 3'b000;
  logic [3:0]  bright = 4'd15;
`ifdef LEADING_ZERO_SUPPRESS_EN
  logic        lz_en = 1'b0;
`endif
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [2:0]  an_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_drv #(.N_DIGITS(N), .SUB_CYC(SC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .bright     (bright),
`ifdef LEADING_ZERO_SUPPRESS_EN
    .lz_en      (lz_en),
`endif
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // At most one anode may ever be driven low.
  always @(negedge clk) begin
    if (rstn) begin
      checks++;
      if ($countones(~an_n) > 1) begin
        errors++;
        $display("FAIL onehot_anodes: an_n=%b required at most one low bit", an_n);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_tick(input bit advance);
    int n;
    if (advance) @(negedge clk);
    n = 0;
    while (frame_tick !== 1'b1 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL frame_tick_wait: frame_tick=%b required=1", frame_tick);
    end
  endtask

  // Expects to start on a frame_tick sample; checks the following 96 cycles.
  task automatic check_frame(input string name,
                             input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [2:0] on,
                             input logic [3:0] br, input logic [2:0] dpm,
                             input int exp_lit, input int chg_at,
                             input logic [11:0] chg_val);
    logic [6:0] code [3];
    int         lit [3];
    int         d, s;
    bit         en;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    code = '{c0, c1, c2};
    lit  = '{0, 0, 0};
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      d = j / SLOT;
      s = (j % SLOT) / SC;
      en = on[d] && (s != 0) && (s <= int'(br));
      exp_an = 3'b111;
      if (en) exp_an[d] = 1'b0;
      exp_seg = en ? ~code[d] : 7'h7F;
      exp_dp  = ~(dpm[d] & en);
      checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL %s cyc=%0d: an_n=%b seg_n=%h dp_n=%b required an_n=%b seg_n=%h dp_n=%b",
                 name, j, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp);
      end
      if (an_n[d] === 1'b0) lit[d]++;
      if (j == chg_at) digits = chg_val;
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (lit[k] != (on[k] ? exp_lit : 0)) begin
        errors++;
        $display("FAIL %s lit_count digit%0d: actual=%0d required=%0d",
                 name, k, lit[k], on[k] ? exp_lit : 0);
      end
    end
  endtask

  task automatic test_reset;
    bit exp_tick;
    rstn = 1'b0; digits = 12'h000; dp = 3'b000; blank = 3'b000; bright = 4'd15;
    repeat (5) @(negedge clk);
    checks++;
    if ({an_n, seg_n, dp_n, frame_tick} !== {3'b111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: an_n=%b seg_n=%h dp_n=%b tick=%b required 111 7f 1 0",
               an_n, seg_n, dp_n, frame_tick);
    end
    rstn = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      exp_tick = (k == FRAME);
      checks++;
      if ({an_n, seg_n, frame_tick} !== {3'b111, 7'h7F, exp_tick}) begin
        errors++;
        $display("FAIL first_frame_dark k=%0d: an_n=%b seg_n=%h tick=%b required 111 7f %b",
                 k, an_n, seg_n, frame_tick, exp_tick);
      end
    end
  endtask

  task automatic test_zero_frame;
    wait_tick(1'b0);
    check_frame("zero_frame", 7'h3F, 7'h3F, 7'h3F, 3'b111, 4'd15, 3'b000, 30, -1, 12'h0);
  endtask

  task automatic test_scan;
    digits = 12'h1A5; dp = 3'b010; bright = 4'd15;
    wait_tick(1'b1);
    check_frame("scan_order", 7'h6D, 7'h77, 7'h06, 3'b111, 4'd15, 3'b010, 30, -1, 12'h0);
  endtask

  task automatic test_brightness;
    dp = 3'b000; bright = 4'd4;
    wait_tick(1'b1);
    check_frame("bright4", 7'h6D, 7'h77, 7'h06, 3'b111, 4'd4, 3'b000, 8, -1, 12'h0);
    bright = 4'd0;
    wait_tick(1'b1);
    check_frame("bright0", 7'h6D, 7'h77, 7'h06, 3'b000, 4'd0, 3'b000, 0, -1, 12'h0);
  endtask

  task automatic test_tearing;
    digits = 12'h123; bright = 4'd15;
    wait_tick(1'b1);
    check_frame("tear_old", 7'h4F, 7'h5B, 7'h06, 3'b111, 4'd15, 3'b000, 30, 40, 12'h456);
    wait_tick(1'b0);
    check_frame("tear_new", 7'h7D, 7'h6D, 7'h66, 3'b111, 4'd15, 3'b000, 30, -1, 12'h0);
  endtask

  task automatic test_blank_wrap;
    digits = 12'h1A5; blank = 3'b100;
    wait_tick(1'b1);
    check_frame("blank_a", 7'h6D, 7'h77, 7'h06, 3'b011, 4'd15, 3'b000, 30, -1, 12'h0);
    wait_tick(1'b0);
    check_frame("blank_b", 7'h6D, 7'h77, 7'h06, 3'b011, 4'd15, 3'b000, 30, -1, 12'h0);
    blank = 3'b000;
  endtask

`ifdef LEADING_ZERO_SUPPRESS_EN
  task automatic test_lz;
    lz_en = 1'b1; blank = 3'b000; bright = 4'd15;
    digits = 12'h007;
    wait_tick(1'b1);
    check_frame("lz_007", 7'h07, 7'h3F, 7'h3F, 3'b001, 4'd15, 3'b000, 30, -1, 12'h0);
    digits = 12'h000;
    wait_tick(1'b1);
    check_frame("lz_000", 7'h3F, 7'h3F, 7'h3F, 3'b001, 4'd15, 3'b000, 30, -1, 12'h0);
    digits = 12'h070;
    wait_tick(1'b1);
    check_frame("lz_070", 7'h3F, 7'h07, 7'h3F, 3'b011, 4'd15, 3'b000, 30, -1, 12'h0);
    lz_en = 1'b0;
  endtask
`endif

  task automatic test_async_reset;
    digits = 12'h888; dp = 3'b111; blank = 3'b000; bright = 4'd15;
    wait_tick(1'b1);
    wait_tick(1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if (an_n !== 3'b101) begin
      errors++;
      $display("FAIL pre_reset_lit: an_n=%b required=101", an_n);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({an_n, seg_n, dp_n, frame_tick} !== {3'b111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_dark: an_n=%b seg_n=%h dp_n=%b tick=%b required 111 7f 1 0",
               an_n, seg_n, dp_n, frame_tick);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({an_n, seg_n} !== {3'b111, 7'h7F}) begin
      errors++;
      $display("FAIL post_reset_dark: an_n=%b seg_n=%h required 111 7f", an_n, seg_n);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_scan();
    test_brightness();
    test_tearing();
    test_blank_wrap();
`ifdef LEADING_ZERO_SUPPRESS_EN
    test_lz();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
